router_bench_axi_multi: RTL

- AXI4-Lite-controlled latency benchmark controller for NUM_COND external condition engines.
- Per run, pulses a common start to all engines and measures cycles until each engine's done strobe, with a per-run timeout.
- Repeats for a programmable run count and accumulates saturating per-condition totals.
- Selects the winner (lowest total), drives one-hot LEDs and an optional level interrupt.

---
 rtl/router_bench_axi_multi.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/router_bench_axi_multi.sv
// AXI4-Lite controlled latency benchmark: starts NUM_COND condition engines together,
// times each one's done strobe over several runs, and reports the lowest accumulated total.
module router_bench_axi_multi #(
  parameter int unsigned NUM_COND    = 4,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEF_RUNS    = 1,
  parameter int unsigned DEF_TIMEOUT = 1000
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic                cond_start,
  input  logic [NUM_COND-1:0] cond_done,
  output logic [NUM_COND-1:0] led,
  output logic                irq
);

  localparam int unsigned IDX_W = (NUM_COND > 1) ? $clog2(NUM_COND) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_RUNS   = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_TMO    = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] A_ONEHOT = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] A_TOTAL  = ADDR_W'(8'h20);
  localparam logic [ADDR_W-1:0] A_TOTEND = A_TOTAL + ADDR_W'(4 * NUM_COND);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_MEASURE, S_ACCUM, S_SCAN, S_DONE} state_t;

  state_t state_q, state_d;

  logic              aw_held, w_held;
  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0]       wdata_q;

  logic                irq_en_q, done_q, aborted_q;
  logic [15:0]         runs_q, runs_left_q;
  logic [CNT_W-1:0]    timeout_q, cyc_q, best_val_q;
  logic [NUM_COND-1:0] tflags_q, captured_q;
  logic [IDX_W-1:0]    win_idx_q, scan_idx_q, best_idx_q;
  logic [CNT_W-1:0]    cap_q   [NUM_COND];
  logic [CNT_W-1:0]    total_q [NUM_COND];

  logic             wr_fire_c, wr_ctrl_c, wr_runs_c, wr_tmo_c, wr_err_c;
  logic             start_c, abort_c, busy_c;
  logic [CNT_W-1:0] cyc_now_c;
  logic             hit_tmo_c, all_cap_c, last_scan_c, scan_take_c;
  logic [IDX_W-1:0] final_idx_c, win_idx_d;
  logic             done_d, aborted_d, irq_en_d;
  logic [CNT_W:0]   sum_c       [NUM_COND];
  logic [CNT_W-1:0] sat_total_c [NUM_COND];
  logic [ADDR_W-1:0] rd_addr_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic [31:0]       rd_data_c;
  logic              rd_err_c;
  logic              unused_wstrb_c;

  // Byte strobes carry no meaning here: every write is a full word.
  assign unused_wstrb_c = ^s_axi_wstrb;

  assign wr_fire_c = aw_held && w_held && !s_axi_bvalid;
  assign wr_ctrl_c = wr_fire_c && (awaddr_q == A_CTRL);
  assign wr_runs_c = wr_fire_c && (awaddr_q == A_RUNS);
  assign wr_tmo_c  = wr_fire_c && (awaddr_q == A_TMO);
  assign wr_err_c  = wr_fire_c && !(wr_ctrl_c || wr_runs_c || wr_tmo_c);
  assign abort_c   = wr_ctrl_c && wdata_q[1];
  assign start_c   = wr_ctrl_c && wdata_q[0] && !wdata_q[1];
  assign busy_c    = (state_q != S_IDLE);

  assign cyc_now_c   = cyc_q + CNT_W'(1);
  assign hit_tmo_c   = (cyc_now_c >= timeout_q);
  assign all_cap_c   = &(captured_q | cond_done);
  assign last_scan_c = (scan_idx_q == IDX_W'(NUM_COND - 1));
  assign scan_take_c = (scan_idx_q == '0) || (total_q[scan_idx_q] < best_val_q);
  assign final_idx_c = scan_take_c ? scan_idx_q : best_idx_q;

  // Saturating accumulation of this run's captures.
  always_comb begin
    for (int i = 0; i < NUM_COND; i++) begin
      sum_c[i]       = {1'b0, total_q[i]} + {1'b0, cap_q[i]};
      sat_total_c[i] = sum_c[i][CNT_W] ? '1 : sum_c[i][CNT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_c && busy_c) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start_c) state_d = S_ARM;
        S_ARM:     state_d = S_MEASURE;
        S_MEASURE: if (all_cap_c || hit_tmo_c) state_d = S_ACCUM;
        S_ACCUM:   state_d = (runs_left_q != 16'd1) ? S_ARM : S_SCAN;
        S_SCAN:    if (last_scan_c) state_d = S_DONE;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Sticky result flags; led and irq are derived from their next values so they track exactly.
  always_comb begin
    done_d    = done_q;
    aborted_d = aborted_q;
    win_idx_d = win_idx_q;
    irq_en_d  = wr_ctrl_c ? wdata_q[2] : irq_en_q;
    if (busy_c) begin
      if (abort_c) begin
        aborted_d = 1'b1;
      end else if (state_q == S_SCAN && last_scan_c) begin
        done_d    = 1'b1;
        win_idx_d = final_idx_c;
      end
    end else if (abort_c || start_c) begin
      done_d    = 1'b0;
      aborted_d = 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      win_idx_q   <= '0;
      runs_q      <= 16'(DEF_RUNS);
      timeout_q   <= CNT_W'(DEF_TIMEOUT);
      runs_left_q <= '0;
      cyc_q       <= '0;
      captured_q  <= '0;
      tflags_q    <= '0;
      scan_idx_q  <= '0;
      best_idx_q  <= '0;
      best_val_q  <= '0;
      cond_start  <= 1'b0;
      led         <= '0;
      irq         <= 1'b0;
      for (int i = 0; i < NUM_COND; i++) begin
        cap_q[i]   <= '0;
        total_q[i] <= '0;
      end
    end else begin
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      win_idx_q  <= win_idx_d;
      cond_start <= (state_d == S_ARM);
      led        <= done_d ? (NUM_COND'(1) << win_idx_d) : '0;
      irq        <= irq_en_d & done_d;
      if (wr_runs_c) runs_q <= wdata_q[15:0];
      if (wr_tmo_c)  timeout_q <= CNT_W'(wdata_q);
      if (!busy_c && start_c) begin
        tflags_q    <= '0;
        runs_left_q <= (runs_q == 16'd0) ? 16'd1 : runs_q;
        for (int i = 0; i < NUM_COND; i++) total_q[i] <= '0;
      end
      if (!(abort_c && busy_c)) begin
        case (state_q)
          S_ARM: begin
            cyc_q      <= '0;
            captured_q <= '0;
          end
          S_MEASURE: begin
            cyc_q <= cyc_now_c;
            for (int i = 0; i < NUM_COND; i++) begin
              if (cond_done[i] && !captured_q[i]) begin
                cap_q[i]      <= cyc_now_c;
                captured_q[i] <= 1'b1;
              end else if (hit_tmo_c && !captured_q[i]) begin
                cap_q[i]    <= timeout_q;
                tflags_q[i] <= 1'b1;
              end
            end
          end
          S_ACCUM: begin
            for (int i = 0; i < NUM_COND; i++) total_q[i] <= sat_total_c[i];
            runs_left_q <= runs_left_q - 16'd1;
            scan_idx_q  <= '0;
          end
          S_SCAN: begin
            if (scan_take_c) begin
              best_val_q <= total_q[scan_idx_q];
              best_idx_q <= scan_idx_q;
            end
            scan_idx_q <= scan_idx_q + IDX_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Write channel: AW and W are captured independently, B issued once both are held.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
    end else begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      if (!aw_held && !s_axi_awready && s_axi_awvalid && !s_axi_bvalid) s_axi_awready <= 1'b1;
      if (!w_held && !s_axi_wready && s_axi_wvalid && !s_axi_bvalid)    s_axi_wready  <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held  <= 1'b1;
        awaddr_q <= s_axi_awaddr & ~ADDR_W'(3);
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_wdata;
      end
      if (wr_fire_c) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_err_c ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // Read decode for the address presented at the AR handshake.
  always_comb begin
    rd_addr_c = s_axi_araddr & ~ADDR_W'(3);
    rd_idx_c  = IDX_W'((rd_addr_c - A_TOTAL) >> 2);
    rd_data_c = '0;
    rd_err_c  = 1'b0;
    if (rd_addr_c == A_CTRL)        rd_data_c = 32'({irq_en_q, 2'b00});
    else if (rd_addr_c == A_STATUS) rd_data_c = {8'h00, 8'(win_idx_q), 8'(tflags_q),
                                                 5'b0, aborted_q, done_q, busy_c};
    else if (rd_addr_c == A_RUNS)   rd_data_c = 32'(runs_q);
    else if (rd_addr_c == A_TMO)    rd_data_c = 32'(timeout_q);
    else if (rd_addr_c == A_ONEHOT) rd_data_c = 32'(led);
    else if (rd_addr_c >= A_TOTAL && rd_addr_c < A_TOTEND) rd_data_c = 32'(total_q[rd_idx_c]);
    else                            rd_err_c  = 1'b1;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      s_axi_arready <= 1'b0;
      if (!s_axi_arready && s_axi_arvalid && !s_axi_rvalid) s_axi_arready <= 1'b1;
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data_c;
        s_axi_rresp  <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule
